multicycle_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle datapath. It runs the team's 32-bit instruction format through a FETCH/DECODE/EXEC/MEM/WB state machine, holds an internal register file, and talks to external instruction and data memories over req/ready handshakes, so memories with wait states are supported. It adds word-width, register-count and PC-width parameters, HALT, illegal-opcode trapping, a retire counter and a debug register read port.

---
 rtl/multicycle_core.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_core.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB sequenced core with req/ready memory ports.
// Rev 1.0
`default_nettype none

module multicycle_core #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int PC_W = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_rdata,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [PC_W-1:0]          dmem_addr,
  output logic [XLEN-1:0]          dmem_wdata,
  input  logic                     dmem_ready,
  input  logic [XLEN-1:0]          dmem_rdata,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic [PC_W-1:0]          pc,
  output logic                     retire,
  output logic [31:0]              retire_count,
  output logic                     halted,
  output logic                     illegal
);

  localparam int RW = $clog2(NREG);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_J    = 6'd8;
  localparam logic [5:0] OP_SLT  = 6'd9;
  localparam logic [5:0] OP_HALT = 6'd63;

  logic [2:0]      state;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] res;

  logic [5:0]      op;
  logic [RW-1:0]   rs_f;
  logic [RW-1:0]   rt_f;
  logic [RW-1:0]   rd_f;
  logic [RW-1:0]   dst;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] addr_sum;
  logic [XLEN-1:0] alu_out;
  logic            is_rtype;

  assign op        = ir[31:26];
  assign rs_f      = ir[21 +: RW];
  assign rt_f      = ir[16 +: RW];
  assign rd_f      = ir[11 +: RW];
  assign imm_x     = XLEN'(ir[15:0]);
  assign addr_sum  = opa + imm_x;
  assign is_rtype  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                     (op == OP_OR)  || (op == OP_SLT);
  assign dst       = is_rtype ? rd_f : rt_f;
  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_addr];

  always_comb begin
    alu_out = '0;
    case (op)
      OP_ADD:  alu_out = opa + opb;
      OP_SUB:  alu_out = opa - opb;
      OP_AND:  alu_out = opa & opb;
      OP_OR:   alu_out = opa | opb;
      OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, (opa < opb)};
      OP_ADDI: alu_out = addr_sum;
      default: alu_out = '0;
    endcase
  end

  // Retire is asserted during the last state of each instruction; for stores
  // that is the MEM cycle in which the data handshake completes.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC:  retire = (op == OP_BEQ) || (op == OP_J) || (op == OP_HALT);
      S_MEM:   retire = dmem_we && dmem_ready;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= '0;
      ir           <= '0;
      opa          <= '0;
      opb          <= '0;
      res          <= '0;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      retire_count <= '0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      retire_count <= retire_count + {31'd0, retire};
      case (state)
        // Coming out of reset FETCH is entered with req low, so raise it here.
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            imem_req <= 1'b0;
            ir       <= imem_rdata;
            pc       <= pc + 1'b1;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa   <= regs[rs_f];
          opb   <= regs[rt_f];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: begin
              res   <= alu_out;
              state <= S_WB;
            end
            OP_LW, OP_SW: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_SW);
              dmem_addr  <= PC_W'(addr_sum);
              dmem_wdata <= opb;
              state      <= S_MEM;
            end
            OP_BEQ: begin
              if (opa == opb) pc <= PC_W'(ir[15:0]);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_J: begin
              pc       <= PC_W'(ir[25:0]);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              res   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (dst != '0) regs[dst] <= res;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: vector table, directed corner sequences and random programs vs. an ISA model.
// Rev 1.0
`default_nettype none

module tb_multicycle_core;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (32-bit, 32 regs, 26-bit PC)
  logic        rst;
  logic        imem_req, imem_ready;
  logic [25:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [25:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [25:0] pc;
  logic        retire, halted, illegal;
  logic [31:0] retire_count;

  multicycle_core #(.XLEN(32), .NREG(32), .PC_W(26)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .retire(retire),
    .retire_count(retire_count), .halted(halted), .illegal(illegal)
  );

  // small instance (16-bit, 8 regs, 4-bit PC)
  logic        rst_s;
  logic        imem_req_s, dmem_req_s, dmem_we_s, retire_s, halted_s, illegal_s;
  logic [3:0]  imem_addr_s, dmem_addr_s, pc_s;
  logic [31:0] imem_rdata_s, rc_s;
  logic [15:0] dmem_wdata_s, dbg_data_s;
  logic [2:0]  dbg_addr_s;
  logic [31:0] imem_s [16];

  assign imem_rdata_s = imem_s[imem_addr_s];

  multicycle_core #(.XLEN(16), .NREG(8), .PC_W(4)) dut_s (
    .clk(clk), .rst(rst_s),
    .imem_req(imem_req_s), .imem_addr(imem_addr_s), .imem_ready(1'b1), .imem_rdata(imem_rdata_s),
    .dmem_req(dmem_req_s), .dmem_we(dmem_we_s), .dmem_addr(dmem_addr_s), .dmem_wdata(dmem_wdata_s),
    .dmem_ready(1'b1), .dmem_rdata(16'h0000),
    .dbg_addr(dbg_addr_s), .dbg_data(dbg_data_s), .pc(pc_s), .retire(retire_s),
    .retire_count(rc_s), .halted(halted_s), .illegal(illegal_s)
  );

  // memories and handshake responders for the main instance
  logic [31:0] imem [256];
  logic [31:0] dmem [logic [25:0]];
  int i_lat = 0, d_lat = 0, i_cnt = 0, d_cnt = 0;

  always @(negedge clk) begin
    if (imem_req) begin
      if (i_cnt >= i_lat) begin
        imem_ready = 1'b1; imem_rdata = imem[imem_addr[7:0]]; i_cnt = 0;
      end else begin
        imem_ready = 1'b0; i_cnt++;
      end
    end else begin
      imem_ready = 1'b0; i_cnt = 0;
    end
    if (dmem_req) begin
      if (d_cnt >= d_lat) begin
        dmem_ready = 1'b1;
        dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : 32'h0;
        d_cnt = 0;
      end else begin
        dmem_ready = 1'b0; d_cnt++;
      end
    end else begin
      dmem_ready = 1'b0; d_cnt = 0;
    end
  end

  always @(posedge clk)
    if (!rst && dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] = dmem_wdata;

  // data-request run monitor: length of each req burst and whether addr/data held
  int   d_run = 0;
  logic d_ok;
  logic [25:0] d_a0;
  logic [31:0] d_w0;
  int   run_q[$];
  logic ok_q[$];
  always @(negedge clk) begin
    if (dmem_req) begin
      if (d_run == 0) begin
        d_a0 = dmem_addr; d_w0 = dmem_wdata; d_ok = 1'b1;
      end else if (dmem_addr != d_a0 || dmem_wdata != d_w0) begin
        d_ok = 1'b0;
      end
      d_run++;
    end else if (d_run != 0) begin
      run_q.push_back(d_run); ok_q.push_back(d_ok); d_run = 0;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input int i, input logic [31:0] exp);
    dbg_addr = 5'(i);
    #1;
    chk(nm, dbg_data, exp);
  endtask

  task automatic chk_reg_s(input string nm, input int i, input logic [15:0] exp);
    dbg_addr_s = 3'(i);
    #1;
    chk(nm, dbg_data_s, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_I;
  endtask

  task automatic restart();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (halted) break;
      if (cyc > 3000) begin
        n_tests++; n_fail++;
        $display("FAIL halt_timeout: halted=%0b after %0d cycles", halted, cyc);
        break;
      end
    end
  endtask

  task automatic wait_rc_s(input logic [31:0] n);
    int k = 0;
    while (rc_s != n && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL wait_rc_s: retire_count=%0d expected %0d", rc_s, n);
    end
  endtask

  // ISA-level reference: interprets imem directly from the instruction rules
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [logic [25:0]];
  logic [25:0] m_pc;
  logic [31:0] m_cnt;

  task automatic model_run();
    logic [25:0] p, ad;
    logic [31:0] ins, a, b, imm, t, v;
    logic [5:0]  op;
    logic [4:0]  rd, rt;
    bit done;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    p = '0; m_cnt = 0; done = 0;
    for (int s = 0; s < 300 && !done; s++) begin
      ins = imem[p[7:0]];
      op = ins[31:26]; rt = ins[20:16]; rd = ins[15:11];
      a = m_reg[ins[25:21]]; b = m_reg[rt];
      imm = {16'h0, ins[15:0]};
      t = a + imm; ad = t[25:0];
      p = p + 26'd1; m_cnt++;
      v = 32'h0;
      case (op)
        6'd0: v = a + b;
        6'd1: v = a - b;
        6'd2: v = a & b;
        6'd3: v = a | b;
        6'd9: v = (a < b) ? 32'd1 : 32'd0;
        6'd4: v = t;
        6'd5: v = m_mem.exists(ad) ? m_mem[ad] : 32'h0;
        6'd6: m_mem[ad] = b;
        6'd7: if (a == b) p = {10'd0, ins[15:0]};
        6'd8: p = ins[25:0];
        default: done = 1;
      endcase
      if (op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd9} && rd != 0) m_reg[rd] = v;
      if (op inside {6'd4, 6'd5} && rt != 0) m_reg[rt] = v;
    end
    m_pc = p;
  endtask

  function automatic logic [31:0] rnd_instr(input int k, input int len);
    logic [5:0] rops [5] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd9};
    logic [4:0] rs, rt, rd;
    int sel, tgt;
    sel = $urandom_range(0, 9);
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    tgt = k + 1 + $urandom_range(0, 2);
    if (tgt > len) tgt = len;
    case (sel)
      5: return itype(6'd4, rs, rt, 16'($urandom));
      6: return itype(6'd5, rs, rt, 16'($urandom_range(0, 63)));
      7: return itype(6'd6, rs, rt, 16'($urandom_range(0, 63)));
      8: return itype(6'd7, rs, ($urandom_range(0, 1) != 0) ? rs : rt, 16'(tgt));
      9: return {6'd8, 26'(tgt)};
      default: return rtype(rops[sel], rs, rt, rd);
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    int          rix;
    logic [31:0] rval;
    int          maddr;
    logic [31:0] mval;
    int          cyc;
    logic [25:0] epc;
  } vec_t;

  vec_t vt [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, nreq;
    rst = 1'b1; rst_s = 1'b1; dbg_addr = '0; dbg_addr_s = '0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    for (int i = 0; i < 16; i++) imem_s[i] = HALT_I;

    vt[0]  = '{rtype(6'd0, 5'd1, 5'd2, 5'd3), 16'd5, 16'd7, 3, 32'd12, -1, 32'd0, 16, 26'd4};
    vt[1]  = '{rtype(6'd1, 5'd2, 5'd1, 5'd4), 16'd5, 16'd7, 4, 32'd2, -1, 32'd0, 16, 26'd4};
    vt[2]  = '{rtype(6'd1, 5'd1, 5'd2, 5'd3), 16'd5, 16'd7, 3, 32'hFFFF_FFFE, -1, 32'd0, 16, 26'd4};
    vt[3]  = '{rtype(6'd2, 5'd1, 5'd2, 5'd3), 16'hF0F0, 16'hFF00, 3, 32'h0000_F000, -1, 32'd0, 16, 26'd4};
    vt[4]  = '{rtype(6'd3, 5'd1, 5'd2, 5'd3), 16'hF0F0, 16'hFF00, 3, 32'h0000_FFF0, -1, 32'd0, 16, 26'd4};
    vt[5]  = '{rtype(6'd9, 5'd1, 5'd2, 5'd3), 16'd5, 16'd7, 3, 32'd1, -1, 32'd0, 16, 26'd4};
    vt[6]  = '{rtype(6'd9, 5'd1, 5'd2, 5'd3), 16'd7, 16'd5, 3, 32'd0, -1, 32'd0, 16, 26'd4};
    vt[7]  = '{itype(6'd4, 5'd1, 5'd3, 16'hFFFF), 16'd5, 16'd7, 3, 32'h0001_0004, -1, 32'd0, 16, 26'd4};
    vt[8]  = '{itype(6'd5, 5'd1, 5'd3, 16'd3), 16'd0, 16'd0, 3, 32'hCAFE_0003, -1, 32'd0, 17, 26'd4};
    vt[9]  = '{itype(6'd6, 5'd1, 5'd2, 16'd1), 16'd2, 16'd7, 2, 32'd7, 3, 32'd7, 16, 26'd4};
    vt[10] = '{itype(6'd7, 5'd1, 5'd2, 16'd10), 16'd5, 16'd5, 1, 32'd5, -1, 32'd0, 15, 26'd11};
    vt[11] = '{itype(6'd7, 5'd1, 5'd2, 16'd10), 16'd5, 16'd7, 2, 32'd7, -1, 32'd0, 15, 26'd4};
    vt[12] = '{{6'd8, 26'd20}, 16'd5, 16'd7, 1, 32'd5, -1, 32'd0, 15, 26'd21};
    vt[13] = '{itype(6'd4, 5'd0, 5'd0, 16'd9), 16'd5, 16'd7, 0, 32'd0, -1, 32'd0, 16, 26'd4};

    repeat (2) @(negedge clk);
    // reset values
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retire", retire, 0);
    chk("rst_retire_count", retire_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);

    // vector table: two ADDI setups, the instruction under test, HALT
    for (int v = 0; v < 14; v++) begin
      clear_imem();
      imem[0] = itype(6'd4, 5'd0, 5'd1, vt[v].a);
      imem[1] = itype(6'd4, 5'd0, 5'd2, vt[v].b);
      imem[2] = vt[v].instr;
      dmem.delete();
      dmem[26'd3] = 32'hCAFE_0003;
      i_lat = 0; d_lat = 0;
      restart();
      run_to_halt(cyc);
      chk($sformatf("vec%0d_cycles", v), cyc, vt[v].cyc);
      chk($sformatf("vec%0d_pc", v), pc, vt[v].epc);
      chk($sformatf("vec%0d_retired", v), retire_count, 4);
      chk_reg($sformatf("vec%0d_reg", v), vt[v].rix, vt[v].rval);
      if (vt[v].maddr >= 0)
        chk($sformatf("vec%0d_mem", v), dmem[26'(vt[v].maddr)], vt[v].mval);
    end

    // basic program; first request must appear one cycle after reset release
    clear_imem();
    imem[0] = itype(6'd4, 5'd0, 5'd1, 16'd5);
    imem[1] = itype(6'd4, 5'd0, 5'd2, 16'd7);
    imem[2] = rtype(6'd0, 5'd1, 5'd2, 5'd3);
    imem[3] = rtype(6'd1, 5'd2, 5'd1, 5'd4);
    restart();
    @(negedge clk);
    chk("first_imem_req", imem_req, 1);
    chk("first_imem_addr", imem_addr, 0);
    run_to_halt(cyc);
    chk_reg("prog_r3", 3, 32'd12);
    chk_reg("prog_r4", 4, 32'd2);
    chk("prog_retired", retire_count, 5);
    chk("prog_halted", halted, 1);
    chk("prog_pc", pc, 5);
    chk("prog_illegal", illegal, 0);

    // store then load with three wait states on the data port
    clear_imem();
    imem[0] = itype(6'd4, 5'd0, 5'd3, 16'd12);
    imem[1] = itype(6'd6, 5'd0, 5'd3, 16'd3);
    imem[2] = itype(6'd5, 5'd0, 5'd5, 16'd3);
    dmem.delete();
    d_lat = 3;
    run_q.delete(); ok_q.delete();
    restart();
    run_to_halt(cyc);
    chk("ws_req_bursts", run_q.size(), 2);
    chk("ws_sw_req_len", run_q[0], 4);
    chk("ws_lw_req_len", run_q[1], 4);
    chk("ws_sw_stable", ok_q[0], 1);
    chk("ws_lw_stable", ok_q[1], 1);
    chk_reg("ws_r5", 5, 32'd12);
    chk("ws_mem3", dmem[26'd3], 32'd12);
    d_lat = 0;

    // illegal opcode traps without retiring
    clear_imem();
    imem[0] = itype(6'd4, 5'd0, 5'd1, 16'd1);
    imem[1] = {6'd12, 26'd0};
    restart();
    run_to_halt(cyc);
    chk("ill_illegal", illegal, 1);
    chk("ill_halted", halted, 1);
    chk("ill_retired", retire_count, 1);
    nreq = 0;
    repeat (10) begin @(negedge clk); if (imem_req || dmem_req) nreq++; end
    chk("ill_no_requests", nreq, 0);

    // asynchronous reset during a stalled fetch
    clear_imem();
    imem[0] = itype(6'd4, 5'd0, 5'd1, 16'd5);
    imem[1] = itype(6'd4, 5'd0, 5'd2, 16'd7);
    i_lat = 0;
    restart();
    cyc = 0;
    while (!retire && cyc < 100) begin @(negedge clk); cyc++; end
    i_lat = 1000;
    repeat (3) @(negedge clk);
    chk("stall_req", imem_req, 1);
    chk("stall_pc", pc, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_drop", imem_req, 0);
    chk("arst_pc", pc, 0);
    chk("arst_retired", retire_count, 0);
    @(negedge clk);
    i_lat = 0;
    rst = 1'b0;
    run_to_halt(cyc);
    chk("arst_restart_cycles", cyc, 12);
    chk_reg("arst_r1", 1, 32'd5);
    chk_reg("arst_r2", 2, 32'd7);
    chk("arst_pc_end", pc, 3);

    // narrow configuration: 16-bit wrap, register-index masking, PC wrap
    imem_s[0]  = itype(6'd4, 5'd0, 5'd1, 16'hFFFF);
    imem_s[1]  = itype(6'd4, 5'd9, 5'd9, 16'd1);
    imem_s[2]  = {6'd8, 26'h3FF_FFFF};
    imem_s[15] = itype(6'd4, 5'd1, 5'd2, 16'd5);
    @(negedge clk);
    rst_s = 1'b0;
    wait_rc_s(1);
    chk_reg_s("s_r1_ffff", 1, 16'hFFFF);
    wait_rc_s(2);
    chk_reg_s("s_r1_wrap", 1, 16'h0000);
    wait_rc_s(3);
    chk("s_jump_pc", pc_s, 15);
    chk("s_fetch15", {imem_req_s, imem_addr_s}, {1'b1, 4'd15});
    wait_rc_s(4);
    chk_reg_s("s_r2", 2, 16'd5);
    chk("s_fetch_wrap", {imem_req_s, imem_addr_s}, {1'b1, 4'd0});
    rst_s = 1'b1;

    // random programs against the ISA model
    for (int p = 0; p < 20; p++) begin
      clear_imem();
      for (int k = 0; k < 14; k++) imem[k] = rnd_instr(k, 14);
      dmem.delete(); m_mem.delete();
      for (int a = 0; a < 64; a++) begin
        logic [31:0] rv;
        rv = $urandom;
        dmem[26'(a)] = rv; m_mem[26'(a)] = rv;
      end
      i_lat = $urandom_range(0, 2);
      d_lat = $urandom_range(0, 2);
      restart();
      run_to_halt(cyc);
      model_run();
      chk($sformatf("rnd%0d_retired", p), retire_count, m_cnt);
      chk($sformatf("rnd%0d_pc", p), pc, m_pc);
      for (int r = 0; r < 32; r++) chk_reg($sformatf("rnd%0d_r%0d", p, r), r, m_reg[r]);
      chk($sformatf("rnd%0d_mem_size", p), dmem.num(), m_mem.num());
      foreach (m_mem[k])
        chk($sformatf("rnd%0d_mem%0h", p, k), dmem.exists(k) ? dmem[k] : 32'hDEAD_BEEF, m_mem[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
